execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Y86-64 pipeline Execute stage. Consumes the E-register outputs, computes the ALU result, maintains the condition-code register and evaluates the branch/cmov condition.
- Registers the results into the M pipeline register on each clock edge.
- Exposes combinational e_* signals for forwarding and for branch-mispredict detection.

Parameters:
- WORD, 64, datapath width (valC/valA/valB/valE).
- RNONE, 4'hF, "no register" destination code.

Ports:
- clk  in  1  pipeline clock, all state on posedge
- reset  in  1  synchronous, active-high
- E_stat  in  3  instruction status from E register
- E_icode  in  4  instruction code
- E_ifun  in  4  function code (ALU op or condition)
- E_valC  in  WORD  constant
- E_valA  in  WORD  operand A / store data
- E_valB  in  WORD  operand B
- E_dstE  in  4  ALU destination register
- E_dstM  in  4  memory destination register
- m_stat  in  3  status currently leaving Memory stage
- W_stat  in  3  status in W register
- M_bubble  in  1  insert bubble into M register this edge
- e_valE  out  WORD  combinational ALU result (forwarding)
- e_dstE  out  4  combinational effective dstE (forwarding)
- e_Cnd  out  1  combinational condition result
- M_stat  out  3  registered status
- M_icode  out  4  registered icode
- M_Cnd  out  1  registered condition
- M_valE  out  WORD  registered ALU result
- M_valA  out  WORD  registered pass-through valA
- M_dstE  out  4  registered dstE
- M_dstM  out  4  registered dstM

Behaviour:
- Encodings:
  - icodes: HALT 0, NOP 1, CMOVXX 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
  - stat: AOK 1, HLT 2, ADR 3, INS 4.
  - ALU fun: ADD 0, SUB 1, AND 2, XOR 3.
  - conditions: ALWAYS 0, LE 1, L 2, E 3, NE 4, GE 5, G 6.
- aluA:
  - OPQ, CMOVXX -> valA
  - IRMOVQ, RMMOVQ, MRMOVQ -> valC
  - CALL, PUSHQ -> -8
  - RET, POPQ -> +8
  - otherwise 0
- aluB:
  - OPQ, RMMOVQ, MRMOVQ, CALL, PUSHQ, RET, POPQ -> valB
  - IRMOVQ, CMOVXX -> 0
  - otherwise 0
- ALU op: E_ifun when icode==OPQ, else ADD.
  - Results: ADD aluB+aluA; SUB aluB-aluA; AND; XOR. Modulo 2^64, no carry out.
  - Undefined ifun (>3) on OPQ -> ADD.
- Flags from the result t:
  - ZF = (t==0)
  - SF = t[63]
  - OF for ADD = (a[63]==b[63]) && (t[63]!=a[63])
  - OF for SUB = (a[63]!=b[63]) && (t[63]!=b[63])
  - OF for AND/XOR = 0
- CC register (ZF, SF, OF):
  - Reset value ZF=1, SF=0, OF=0.
  - set_cc = (E_icode==OPQ) && m_stat and W_stat both AOK. set_cc is independent of M_bubble.
  - CC loads new flags on the edge when set_cc=1; otherwise holds.
  - reset overrides set_cc.
- e_Cnd is evaluated from the current (pre-update) CC:
  - LE (SF^OF)|ZF
  - L SF^OF
  - E ZF
  - NE !ZF
  - GE !(SF^OF)
  - G !(SF^OF)&!ZF
  - ALWAYS 1
  - ifun>6 -> 0
- e_dstE = RNONE when icode==CMOVXX && !e_Cnd; else E_dstE.
- M register update priority, per edge: reset > M_bubble > load.
  - reset and bubble both write: M_stat=AOK, M_icode=NOP, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=RNONE.
  - load writes: M_stat=E_stat, M_icode=E_icode, M_Cnd=e_Cnd, M_valE=e_valE, M_valA=E_valA, M_dstE=e_dstE, M_dstM=E_dstM.
- Latency: one cycle from E_* to M_*. e_* outputs are purely combinational, same cycle.
- An instruction with E_stat != AOK still computes and loads into M normally; only CC updates are gated, via m_stat/W_stat.
- Reset asserted mid-stream: everything is flushed on that edge. The first load is on the first edge with reset low.

Decomposition:
- Package y86_pkg holds:
  - icode, stat, ALU-fun and condition constants
  - RNONE
  - the WORD width
- Sub-module alu_64: combinational. Inputs aluA, aluB, fun. Outputs valE, zf, sf, of.
- CC register, condition logic and M register stay in execute_stage.

Test Plan:
- Reset: reset=1 for one edge -> M_icode=1, M_stat=1, M_dstE=M_dstM=F, M_valE=0. A following JXX with ifun=E (3) gives e_Cnd=1, since reset leaves ZF=1.
- OPQ ADD overflow: valA=0x7FFF_FFFF_FFFF_FFFF, valB=1, dstE=3 -> e_valE=0x8000_0000_0000_0000. Next edge: CC becomes ZF=0, SF=1, OF=1, and M_valE/M_dstE=3 are registered.
- SUB sets equal: ifun=1, valA=valB=5 -> valE=0, ZF=1. Next cycle CMOVXX ifun=1 (LE), dstE=2 -> e_Cnd=1, e_dstE=2. With CC ZF=0, SF=0, OF=0 instead -> e_dstE=F, M_Cnd=0.
- Stack ops: PUSHQ valB=0x100 -> e_valE=0xF8. POPQ valB=0x100 -> e_valE=0x108. MRMOVQ valC=8, valB=0x20 -> 0x28. IRMOVQ valC=0x55 -> 0x55.
- CC suppression: OPQ XOR producing 0 while m_stat=3 (ADR) -> CC unchanged. Same with W_stat=2 (HLT) -> unchanged.
- Bubble: M_bubble=1 during an OPQ load -> M_icode=1, M_dstE=F, M_valE=0, but CC still updates. reset and M_bubble together -> reset values.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and datapath width for the pipeline stages.
// Instruction, status, ALU-function and condition codes all live here.
package y86_pkg;

   localparam int WORD = 64;

   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   // Stack pointer adjustment for call/push (negated) and ret/pop.
   localparam logic [WORD-1:0] STACK_STEP = 64'd8;

endpackage

// File: rtl/alu_64.sv
// Combinational 64-bit ALU: add, sub, and, xor with zero/sign/overflow flags.
// Unknown function codes fall back to add.
module alu_64
   import y86_pkg::*;
(
   input  logic [WORD-1:0] aluA,
   input  logic [WORD-1:0] aluB,
   input  logic [3:0]      fun,
   output logic [WORD-1:0] valE,
   output logic            zf,
   output logic            sf,
   output logic            of
);

   logic [WORD-1:0] sum;
   logic [WORD-1:0] diff;
   logic [WORD-1:0] and_bits;
   logic [WORD-1:0] xor_bits;

   assign sum  = aluB + aluA;
   assign diff = aluB - aluA;

   genvar gi;
   generate
      for (gi = 0; gi < WORD; gi++) begin : g_logic
         assign and_bits[gi] = aluA[gi] & aluB[gi];
         assign xor_bits[gi] = aluA[gi] ^ aluB[gi];
      end
   endgenerate

   always_comb begin
      valE = sum;
      of   = (aluA[WORD-1] == aluB[WORD-1]) && (sum[WORD-1] != aluA[WORD-1]);
      case (fun)
         ALU_SUB: begin
            valE = diff;
            of   = (aluA[WORD-1] != aluB[WORD-1]) && (diff[WORD-1] != aluB[WORD-1]);
         end
         ALU_AND: begin
            valE = and_bits;
            of   = 1'b0;
         end
         ALU_XOR: begin
            valE = xor_bits;
            of   = 1'b0;
         end
         default: ;
      endcase
   end

   assign zf = (valE == '0);
   assign sf = valE[WORD-1];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 Execute stage: operand selection, ALU, condition codes, branch/cmov
// condition and the M pipeline register.
module execute_stage
   import y86_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [2:0]      E_stat,
   input  logic [3:0]      E_icode,
   input  logic [3:0]      E_ifun,
   input  logic [WORD-1:0] E_valC,
   input  logic [WORD-1:0] E_valA,
   input  logic [WORD-1:0] E_valB,
   input  logic [3:0]      E_dstE,
   input  logic [3:0]      E_dstM,
   input  logic [2:0]      m_stat,
   input  logic [2:0]      W_stat,
   input  logic            M_bubble,
   output logic [WORD-1:0] e_valE,
   output logic [3:0]      e_dstE,
   output logic            e_Cnd,
   output logic [2:0]      M_stat,
   output logic [3:0]      M_icode,
   output logic            M_Cnd,
   output logic [WORD-1:0] M_valE,
   output logic [WORD-1:0] M_valA,
   output logic [3:0]      M_dstE,
   output logic [3:0]      M_dstM
);

   logic [WORD-1:0] alu_a;
   logic [WORD-1:0] alu_b;
   logic [3:0]      alu_fun;
   logic            alu_zf;
   logic            alu_sf;
   logic            alu_of;

   logic            zf_reg;
   logic            sf_reg;
   logic            of_reg;
   logic            set_cc;
   logic            cnd;

   logic [2:0]      M_stat_reg;
   logic [3:0]      M_icode_reg;
   logic            M_Cnd_reg;
   logic [WORD-1:0] M_valE_reg;
   logic [WORD-1:0] M_valA_reg;
   logic [3:0]      M_dstE_reg;
   logic [3:0]      M_dstM_reg;

   always_comb begin
      alu_a = '0;
      case (E_icode)
         I_OPQ, I_CMOVXX:                alu_a = E_valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   alu_a = E_valC;
         I_CALL, I_PUSHQ:                alu_a = -STACK_STEP;
         I_RET, I_POPQ:                  alu_a = STACK_STEP;
         default:                        alu_a = '0;
      endcase
   end

   always_comb begin
      alu_b = '0;
      case (E_icode)
         I_OPQ, I_RMMOVQ, I_MRMOVQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB;
         default:                                                   alu_b = '0;
      endcase
   end

   assign alu_fun = (E_icode == I_OPQ) ? E_ifun : ALU_ADD;

   alu_64 u_alu (
      .aluA (alu_a),
      .aluB (alu_b),
      .fun  (alu_fun),
      .valE (e_valE),
      .zf   (alu_zf),
      .sf   (alu_sf),
      .of   (alu_of)
   );

   // Condition is judged on the flags left by the previous OPq, not this one.
   always_comb begin
      cnd = 1'b0;
      case (E_ifun)
         C_ALWAYS: cnd = 1'b1;
         C_LE:     cnd = (sf_reg ^ of_reg) | zf_reg;
         C_L:      cnd = sf_reg ^ of_reg;
         C_E:      cnd = zf_reg;
         C_NE:     cnd = ~zf_reg;
         C_GE:     cnd = ~(sf_reg ^ of_reg);
         C_G:      cnd = ~(sf_reg ^ of_reg) & ~zf_reg;
         default:  cnd = 1'b0;
      endcase
   end

   assign e_Cnd  = cnd;
   assign e_dstE = (E_icode == I_CMOVXX && !cnd) ? RNONE : E_dstE;

   // An exception downstream must not let later instructions alter the flags.
   assign set_cc = (E_icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK);

   always_ff @(posedge clk) begin
      if (reset) begin
         zf_reg <= 1'b1;
         sf_reg <= 1'b0;
         of_reg <= 1'b0;
      end else if (set_cc) begin
         zf_reg <= alu_zf;
         sf_reg <= alu_sf;
         of_reg <= alu_of;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || M_bubble) begin
         M_stat_reg  <= S_AOK;
         M_icode_reg <= I_NOP;
         M_Cnd_reg   <= 1'b0;
         M_valE_reg  <= '0;
         M_valA_reg  <= '0;
         M_dstE_reg  <= RNONE;
         M_dstM_reg  <= RNONE;
      end else begin
         M_stat_reg  <= E_stat;
         M_icode_reg <= E_icode;
         M_Cnd_reg   <= cnd;
         M_valE_reg  <= e_valE;
         M_valA_reg  <= E_valA;
         M_dstE_reg  <= e_dstE;
         M_dstM_reg  <= E_dstM;
      end
   end

   assign M_stat  = M_stat_reg;
   assign M_icode = M_icode_reg;
   assign M_Cnd   = M_Cnd_reg;
   assign M_valE  = M_valE_reg;
   assign M_valA  = M_valA_reg;
   assign M_dstE  = M_dstE_reg;
   assign M_dstM  = M_dstM_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed table, hand-written sequences and random
// stimulus checked against an arithmetic reference model.
module tb_execute_stage;
   import y86_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  E_stat;
   logic [3:0]  E_icode;
   logic [3:0]  E_ifun;
   logic [63:0] E_valC;
   logic [63:0] E_valA;
   logic [63:0] E_valB;
   logic [3:0]  E_dstE;
   logic [3:0]  E_dstM;
   logic [2:0]  m_stat;
   logic [2:0]  W_stat;
   logic        M_bubble;
   logic [63:0] e_valE;
   logic [3:0]  e_dstE;
   logic        e_Cnd;
   logic [2:0]  M_stat;
   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valE;
   logic [63:0] M_valA;
   logic [3:0]  M_dstE;
   logic [3:0]  M_dstM;

   execute_stage dut (
      .clk(clk), .reset(reset),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM),
      .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
      .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
      .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
      .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference condition codes
   logic mzf, msf, mof;

   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] valC;
      logic [63:0] valA;
      logic [63:0] valB;
      logic [63:0] exp_valE;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference ALU: 65-bit signed arithmetic, overflow when the result does not fit in 64 bits.
   function automatic void model_alu(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] t, output logic zf, output logic sf, output logic of);
      logic [63:0] x, y;
      logic [3:0]  op;
      logic signed [64:0] wide;
      case (ic)
         I_OPQ, I_CMOVXX:              x = a;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: x = c;
         I_CALL, I_PUSHQ:              x = 64'hFFFF_FFFF_FFFF_FFF8;
         I_RET, I_POPQ:                x = 64'd8;
         default:                      x = 64'd0;
      endcase
      case (ic)
         I_OPQ, I_RMMOVQ, I_MRMOVQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: y = b;
         default: y = 64'd0;
      endcase
      op = (ic == I_OPQ && fn <= 4'd3) ? fn : 4'd0;
      of = 1'b0;
      case (op)
         4'd1: begin
            wide = $signed({y[63], y}) - $signed({x[63], x});
            t = wide[63:0];
            of = wide[64] != wide[63];
         end
         4'd2: t = y & x;
         4'd3: t = y ^ x;
         default: begin
            wide = $signed({y[63], y}) + $signed({x[63], x});
            t = wide[63:0];
            of = wide[64] != wide[63];
         end
      endcase
      zf = (t == 64'd0);
      sf = t[63];
   endfunction

   function automatic logic model_cnd(input logic [3:0] fn);
      case (fn)
         4'd0: return 1'b1;
         4'd1: return (msf ^ mof) | mzf;
         4'd2: return msf ^ mof;
         4'd3: return mzf;
         4'd4: return !mzf;
         4'd5: return !(msf ^ mof);
         4'd6: return !(msf ^ mof) && !mzf;
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_in(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                         input logic [63:0] a, input logic [63:0] b, input logic [3:0] de);
      E_stat = S_AOK; E_icode = ic; E_ifun = fn; E_valC = c; E_valA = a; E_valB = b;
      E_dstE = de; E_dstM = 4'h7; m_stat = S_AOK; W_stat = S_AOK; M_bubble = 1'b0; reset = 1'b0;
   endtask

   // One cycle: check combinational outputs, clock, check the M register, advance the model.
   task automatic step();
      logic [63:0] t;
      logic zf, sf, of, cnd, setcc;
      logic [3:0] dste;
      model_alu(E_icode, E_ifun, E_valC, E_valA, E_valB, t, zf, sf, of);
      cnd = model_cnd(E_ifun);
      dste = (E_icode == I_CMOVXX && !cnd) ? RNONE : E_dstE;
      setcc = (E_icode == I_OPQ) && m_stat == S_AOK && W_stat == S_AOK;
      #1;
      if (!reset) begin
         chk("e_valE", e_valE, t);
         chk("e_Cnd", {63'd0, e_Cnd}, {63'd0, cnd});
         chk("e_dstE", {60'd0, e_dstE}, {60'd0, dste});
      end
      @(posedge clk);
      #1;
      if (reset || M_bubble) begin
         chk("M_stat_flush", {61'd0, M_stat}, {61'd0, S_AOK});
         chk("M_icode_flush", {60'd0, M_icode}, {60'd0, I_NOP});
         chk("M_Cnd_flush", {63'd0, M_Cnd}, 64'd0);
         chk("M_valE_flush", M_valE, 64'd0);
         chk("M_valA_flush", M_valA, 64'd0);
         chk("M_dstE_flush", {60'd0, M_dstE}, {60'd0, RNONE});
         chk("M_dstM_flush", {60'd0, M_dstM}, {60'd0, RNONE});
      end else begin
         chk("M_stat", {61'd0, M_stat}, {61'd0, E_stat});
         chk("M_icode", {60'd0, M_icode}, {60'd0, E_icode});
         chk("M_Cnd", {63'd0, M_Cnd}, {63'd0, cnd});
         chk("M_valE", M_valE, t);
         chk("M_valA", M_valA, E_valA);
         chk("M_dstE", {60'd0, M_dstE}, {60'd0, dste});
         chk("M_dstM", {60'd0, M_dstM}, {60'd0, E_dstM});
      end
      if (reset) begin
         mzf = 1'b1; msf = 1'b0; mof = 1'b0;
      end else if (setcc) begin
         mzf = zf; msf = sf; mof = of;
      end
   endtask

   initial begin
      mzf = 1'b1; msf = 1'b0; mof = 1'b0;

      // reset, then JXX E must be taken because reset leaves ZF set
      set_in(I_NOP, 4'd0, 64'd0, 64'd0, 64'd0, 4'h0);
      reset = 1'b1;
      step();
      chk("reset_M_icode", {60'd0, M_icode}, 64'd1);
      chk("reset_M_dstE", {60'd0, M_dstE}, 64'hF);
      set_in(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
      #1 chk("reset_jxx_e", {63'd0, e_Cnd}, 64'd1);
      step();

      // add overflow -> ZF=0 SF=1 OF=1
      set_in(I_OPQ, ALU_ADD, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd3);
      #1 chk("ovf_valE", e_valE, 64'h8000_0000_0000_0000);
      step();
      chk("ovf_M_dstE", {60'd0, M_dstE}, 64'd3);
      set_in(I_JXX, C_L, 64'd0, 64'd0, 64'd0, RNONE);
      #1 chk("ovf_jl", {63'd0, e_Cnd}, 64'd0);
      E_ifun = C_GE;
      #1 chk("ovf_jge", {63'd0, e_Cnd}, 64'd1);
      E_ifun = C_NE;
      #1 chk("ovf_jne", {63'd0, e_Cnd}, 64'd1);

      // sub to equal, then cmovle writes
      set_in(I_OPQ, ALU_SUB, 64'd0, 64'd5, 64'd5, 4'd1);
      #1 chk("sub_eq_valE", e_valE, 64'd0);
      step();
      set_in(I_CMOVXX, C_LE, 64'd0, 64'h1234, 64'd0, 4'd2);
      #1 chk("cmovle_taken", {60'd0, e_dstE}, 64'd2);
      step();
      // positive result clears all flags, cmovle suppressed
      set_in(I_OPQ, ALU_ADD, 64'd0, 64'd1, 64'd1, 4'd1);
      step();
      set_in(I_CMOVXX, C_LE, 64'd0, 64'h1234, 64'd0, 4'd2);
      #1 chk("cmovle_not", {60'd0, e_dstE}, 64'hF);
      step();
      chk("cmovle_M_Cnd", {63'd0, M_Cnd}, 64'd0);

      // directed operand-selection table
      vecs[0] = '{I_PUSHQ,  4'd0, 64'd0,    64'd0, 64'h100, 64'hF8};
      vecs[1] = '{I_POPQ,   4'd0, 64'd0,    64'd0, 64'h100, 64'h108};
      vecs[2] = '{I_MRMOVQ, 4'd0, 64'd8,    64'd0, 64'h20,  64'h28};
      vecs[3] = '{I_IRMOVQ, 4'd0, 64'h55,   64'd9, 64'h99,  64'h55};
      vecs[4] = '{I_OPQ,    4'd2, 64'd0,    64'hF0F0, 64'h0FF0, 64'h00F0};
      vecs[5] = '{I_OPQ,    4'd9, 64'd0,    64'd3, 64'd4,  64'd7};
      for (int i = 0; i < 6; i++) begin
         set_in(vecs[i].icode, vecs[i].ifun, vecs[i].valC, vecs[i].valA, vecs[i].valB, 4'd4);
         #1 chk($sformatf("table_%0d_valE", i), e_valE, vecs[i].exp_valE);
         step();
      end

      // CC suppression: make ZF=0 first, then XOR-to-zero must not set it
      set_in(I_OPQ, ALU_ADD, 64'd0, 64'd1, 64'd1, 4'd1);
      step();
      set_in(I_OPQ, ALU_XOR, 64'd0, 64'd6, 64'd6, 4'd1);
      m_stat = S_ADR;
      step();
      set_in(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
      #1 chk("supp_mstat", {63'd0, e_Cnd}, 64'd0);
      set_in(I_OPQ, ALU_XOR, 64'd0, 64'd6, 64'd6, 4'd1);
      W_stat = S_HLT;
      step();
      set_in(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
      #1 chk("supp_wstat", {63'd0, e_Cnd}, 64'd0);

      // bubble flushes M but CC still updates
      set_in(I_OPQ, ALU_XOR, 64'd0, 64'd7, 64'd7, 4'd1);
      M_bubble = 1'b1;
      step();
      chk("bubble_M_valE", M_valE, 64'd0);
      set_in(I_JXX, C_E, 64'd0, 64'd0, 64'd0, RNONE);
      #1 chk("bubble_cc", {63'd0, e_Cnd}, 64'd1);
      set_in(I_OPQ, ALU_ADD, 64'd0, 64'd1, 64'd1, 4'd1);
      reset = 1'b1; M_bubble = 1'b1;
      step();
      chk("rst_bubble_icode", {60'd0, M_icode}, 64'd1);

      // random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         logic [63:0] a, b;
         a = {$urandom, $urandom};
         b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a = {60'd0, 4'($urandom)};
         set_in(4'($urandom_range(0, 11)), 4'($urandom_range(0, 7)), {$urandom, $urandom}, a, b,
                4'($urandom));
         E_dstM   = 4'($urandom);
         E_stat   = 3'($urandom_range(1, 4));
         m_stat   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 4)) : S_AOK;
         W_stat   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 4)) : S_AOK;
         M_bubble = ($urandom_range(0, 9) == 0);
         reset    = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 2) == 0) E_icode = I_OPQ;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
